conv_pe: RTL and testbench

CONV_PE -- requirements
Module: conv_pe

---
 rtl/conv_pe_if.sv | 25 ++
 rtl/conv_pe.sv | 143 ++++++++++++++
 tb/tb_conv_pe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pe_if.sv
// rtl/conv_pe_if.sv - conv_pe signal bundle: sample stream, weights, DSP mode and result streams
interface conv_pe_if #(
  parameter int KK = 1
);
  logic                 rstn;
  logic [8:0]           opmode;
  logic [4:0]           inmode;
  logic signed [29:0]   data_fm;
  logic [KK*18-1:0]     weight;
  logic                 in_en;
  logic                 out_en;
  logic signed [47:0]   p;
  logic                 relu_en;
  logic signed [47:0]   relu_data;

  modport master (
    output rstn, opmode, inmode, data_fm, weight, in_en,
    input  out_en, p, relu_en, relu_data
  );

  modport slave (
    input  rstn, opmode, inmode, data_fm, weight, in_en,
    output out_en, p, relu_en, relu_data
  );
endinterface

// File: rtl/conv_pe.sv
// rtl/conv_pe.sv - streaming KxK convolution PE with line buffers, 3-stage MAC pipeline and ReLU
module conv_pe #(
  parameter int KERNEL_SIZE = 1,
  parameter int FM_SIZE     = 2,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1
) (
  input  logic                                     i_clk,
  input  logic                                     i_rstn,
  input  logic [8:0]                               OPMODE,
  input  logic [4:0]                               INMODE,
  input  logic signed [29:0]                       i_DataFM,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*18-1:0]    i_Weight,
  input  logic                                     i_en,
  output logic                                     o_en,
  output logic signed [47:0]                       o_P,
  output logic                                     o_relu_en,
  output logic signed [47:0]                       o_relu_data
);
  localparam int K  = KERNEL_SIZE;
  localparam int W  = FM_SIZE + 2 * PADDING;
  localparam int S  = STRIDE;
  localparam int KK = K * K;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0]      row_q, row_d, col_q, col_d;
  logic signed [29:0] col_v [K];
  logic signed [29:0] win_q [K][K];
  logic signed [29:0] win_d [K][K];
  logic signed [47:0] prod_q [KK];
  logic signed [47:0] prod_d [KK];
  logic signed [47:0] sum_q, sum_d;
  logic signed [47:0] p_q, p_d;
  logic signed [47:0] relu_q, relu_d;
  logic               v0_q, v0_d, v1_q, v2_q, en_q, relu_en_q;
  logic               win_ok, mode_ok;
  logic [31:0]        r32, c32;

  assign r32     = 32'(row_q);
  assign c32     = 32'(col_q);
  assign mode_ok = (OPMODE == 9'h035) && (INMODE == 5'h04);

  // window is judged at the position of the sample being accepted (its bottom-right corner)
  assign win_ok = (r32 >= 32'(K - 1)) && (c32 >= 32'(K - 1)) &&
                  (((r32 - 32'(K - 1)) % 32'(S)) == 32'd0) &&
                  (((c32 - 32'(K - 1)) % 32'(S)) == 32'd0);

  // column feeding the window: older rows from the line buffers, newest row is the live sample
  generate
    if (K > 1) begin : g_lb
      logic signed [29:0] lb_q [K-1][W];
      logic signed [29:0] lb_d [K-1][W];

      always_comb begin
        lb_d = lb_q;
        for (int i = 0; i < K - 1; i++) col_v[i] = lb_q[i][col_q];
        col_v[K-1] = i_DataFM;
        if (i_en) begin
          for (int i = 0; i < K - 1; i++) lb_d[i][col_q] = col_v[i+1];
        end
      end

      always_ff @(posedge i_clk) begin
        lb_q <= lb_d;
      end
    end else begin : g_nolb
      always_comb col_v[0] = i_DataFM;
    end
  endgenerate

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    win_d = win_q;
    v0_d  = 1'b0;
    if (i_en) begin
      v0_d = win_ok;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][K-1] = col_v[i];
      end
      if (col_q == CW'(W - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(W - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod_d[i*K+j] = 48'(win_q[i][j]) * 48'($signed(i_Weight[(i*K+j)*18 +: 18]));
      end
    end
    sum_d = '0;
    for (int t = 0; t < KK; t++) sum_d = sum_d + prod_q[t];
  end

  always_comb begin
    p_d    = p_q;
    relu_d = relu_q;
    if (v2_q) p_d = mode_ok ? sum_q : '0;
    if (en_q) relu_d = p_q[47] ? '0 : p_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      row_q     <= '0;
      col_q     <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      en_q      <= 1'b0;
      p_q       <= '0;
      relu_en_q <= 1'b0;
      relu_q    <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      v0_q      <= v0_d;
      v1_q      <= v0_q;
      v2_q      <= v1_q;
      en_q      <= v2_q;
      p_q       <= p_d;
      relu_en_q <= en_q;
      relu_q    <= relu_d;
    end
  end

  // datapath registers carry no reset; validity travels with the v*_q flags
  always_ff @(posedge i_clk) begin
    win_q  <= win_d;
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  assign o_en        = en_q;
  assign o_P         = p_q;
  assign o_relu_en   = relu_en_q;
  assign o_relu_data = relu_q;
endmodule

// File: tb/tb_conv_pe.sv
// tb/tb_conv_pe.sv - scoreboard bench for conv_pe across three kernel/stride configurations
module tb_conv_pe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_pe_if #(.KK(1)) ia ();
  conv_pe_if #(.KK(4)) ib ();
  conv_pe_if #(.KK(4)) ic ();

  conv_pe #(.KERNEL_SIZE(1), .FM_SIZE(2), .PADDING(0), .STRIDE(1)) u_a (
    .i_clk(clk), .i_rstn(ia.rstn), .OPMODE(ia.opmode), .INMODE(ia.inmode),
    .i_DataFM(ia.data_fm), .i_Weight(ia.weight), .i_en(ia.in_en),
    .o_en(ia.out_en), .o_P(ia.p), .o_relu_en(ia.relu_en), .o_relu_data(ia.relu_data)
  );
  conv_pe #(.KERNEL_SIZE(2), .FM_SIZE(3), .PADDING(0), .STRIDE(1)) u_b (
    .i_clk(clk), .i_rstn(ib.rstn), .OPMODE(ib.opmode), .INMODE(ib.inmode),
    .i_DataFM(ib.data_fm), .i_Weight(ib.weight), .i_en(ib.in_en),
    .o_en(ib.out_en), .o_P(ib.p), .o_relu_en(ib.relu_en), .o_relu_data(ib.relu_data)
  );
  conv_pe #(.KERNEL_SIZE(2), .FM_SIZE(4), .PADDING(0), .STRIDE(2)) u_c (
    .i_clk(clk), .i_rstn(ic.rstn), .OPMODE(ic.opmode), .INMODE(ic.inmode),
    .i_DataFM(ic.data_fm), .i_Weight(ic.weight), .i_en(ic.in_en),
    .o_en(ic.out_en), .o_P(ic.p), .o_relu_en(ic.relu_en), .o_relu_data(ic.relu_data)
  );

  typedef struct {
    int     sel;
    longint val;
    int     due;
  } exp_t;

  exp_t   sb[$];
  exp_t   rq[$];
  int     n_chk = 0;
  int     n_err = 0;
  int     mr, mc, ck, cw, cs;
  longint frame [8][8];
  longint wts [4];
  bit     mode_ok;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic mon(input int sel, input logic oe, input logic signed [47:0] p,
                     input logic re, input logic signed [47:0] rd);
    exp_t e;
    if (oe) begin
      if (sb.size() == 0) check("o_en_unexpected", sel, -1);
      else begin
        e = sb.pop_front();
        check("o_en_sel", sel, e.sel);
        check("o_P", p, e.val);
        check("o_P_latency", cyc, e.due);
        rq.push_back('{sel, (e.val < 0) ? 64'sd0 : e.val, cyc + 1});
      end
    end
    if (re) begin
      if (rq.size() == 0) check("relu_unexpected", sel, -1);
      else begin
        e = rq.pop_front();
        check("relu_sel", sel, e.sel);
        check("o_relu_data", rd, e.val);
        check("relu_latency", cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.out_en, ia.p, ia.relu_en, ia.relu_data);
    mon(1, ib.out_en, ib.p, ib.relu_en, ib.relu_data);
    mon(2, ic.out_en, ic.p, ic.relu_en, ic.relu_data);
  end

  function automatic longint win_sum();
    logic signed [47:0] acc;
    acc = '0;
    for (int i = 0; i < ck; i++)
      for (int j = 0; j < ck; j++)
        acc = acc + 48'(frame[mr-ck+1+i][mc-ck+1+j] * wts[i*ck+j]);
    return mode_ok ? longint'(acc) : 64'sd0;
  endfunction

  task automatic set_cfg(input int sel);
    case (sel)
      0:       begin ck = 1; cw = 2; cs = 1; end
      1:       begin ck = 2; cw = 3; cs = 1; end
      default: begin ck = 2; cw = 4; cs = 2; end
    endcase
    mr = 0;
    mc = 0;
  endtask

  task automatic load_w(input int sel);
    for (int t = 0; t < 4; t++) begin
      if (sel == 0 && t == 0) ia.weight = 18'(wts[0]);
      if (sel == 1) ib.weight[t*18 +: 18] = 18'(wts[t]);
      if (sel == 2) ic.weight[t*18 +: 18] = 18'(wts[t]);
    end
  endtask

  task automatic drive(input int sel, input bit en, input longint d);
    case (sel)
      0:       begin ia.in_en = en; ia.data_fm = 30'(d); end
      1:       begin ib.in_en = en; ib.data_fm = 30'(d); end
      default: begin ic.in_en = en; ic.data_fm = 30'(d); end
    endcase
    @(posedge clk);
    #1;
    if (en) begin
      frame[mr][mc] = d;
      if (mr >= ck - 1 && mc >= ck - 1 && (mr - ck + 1) % cs == 0 && (mc - ck + 1) % cs == 0)
        sb.push_back('{sel, win_sum(), cyc + 3});
      mc++;
      if (mc == cw) begin
        mc = 0;
        mr = (mr + 1 == cw) ? 0 : mr + 1;
      end
    end
  endtask

  task automatic idle(input int sel, input int n);
    for (int k = 0; k < n; k++) drive(sel, 1'b0, 0);
  endtask

  task automatic drain(input int sel, input string tag);
    idle(sel, 8);
    check({tag, "_pending"}, sb.size() + rq.size(), 0);
  endtask

  task automatic stream(input int sel, input int first, input int last);
    for (int v = first; v <= last; v++) drive(sel, 1'b1, v);
  endtask

  initial begin
    ia.rstn = 0; ib.rstn = 0; ic.rstn = 0;
    ia.in_en = 0; ib.in_en = 0; ic.in_en = 0;
    ia.data_fm = 0; ib.data_fm = 0; ic.data_fm = 0;
    ia.weight = 0; ib.weight = 0; ic.weight = 0;
    ia.opmode = 9'h035; ib.opmode = 9'h035; ic.opmode = 9'h035;
    ia.inmode = 5'h04; ib.inmode = 5'h04; ic.inmode = 5'h04;
    mode_ok = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_en", ia.out_en, 0);
    check("rst_o_P", ia.p, 0);
    check("rst_relu_en", ib.relu_en, 0);
    check("rst_relu_data", ic.relu_data, 0);
    ia.rstn = 1; ib.rstn = 1; ic.rstn = 1;

    // K=1 pass-through, then -1 weight, then an unsupported DSP mode
    set_cfg(0);
    wts[0] = 1; load_w(0);
    drive(0, 1, 1); drive(0, 1, 2); drive(0, 1, -10); drive(0, 1, 4);
    drain(0, "k1_pass");
    wts[0] = -1; load_w(0);
    drive(0, 1, 5); drive(0, 1, -3); drive(0, 1, 0); drive(0, 1, 7);
    drain(0, "k1_neg");
    ia.opmode = 9'h000; mode_ok = 0; wts[0] = 1; load_w(0);
    stream(0, 1, 4);
    drain(0, "k1_mode");
    ia.opmode = 9'h035; mode_ok = 1;

    // K=2, W=3, stride 1: plain frame, stalled frame, reset mid-frame
    set_cfg(1);
    for (int t = 0; t < 4; t++) wts[t] = 1;
    load_w(1);
    stream(1, 1, 9);
    drain(1, "k2_plain");
    stream(1, 1, 5); idle(1, 3); stream(1, 6, 9);
    drain(1, "k2_stall");
    stream(1, 1, 4);
    ib.rstn = 0; ib.in_en = 0;
    @(posedge clk); #1;
    check("midrst_o_en", ib.out_en, 0);
    check("midrst_o_P", ib.p, 0);
    check("midrst_relu_en", ib.relu_en, 0);
    check("midrst_relu_data", ib.relu_data, 0);
    ib.rstn = 1;
    set_cfg(1);
    stream(1, 1, 9);
    drain(1, "k2_after_rst");

    // distinct signed taps over two back-to-back frames
    wts[0] = 3; wts[1] = -2; wts[2] = 5; wts[3] = -7;
    load_w(1);
    for (int k = 0; k < 18; k++) drive(1, 1, longint'($urandom_range(0, 2000)) - 1000);
    drain(1, "k2_taps");

    // K=2, W=4, stride 2
    set_cfg(2);
    for (int t = 0; t < 4; t++) wts[t] = 1;
    load_w(2);
    stream(2, 1, 16);
    drain(2, "k2_s2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
